// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift sequencer: op codes, FSM states, default width.
package shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  localparam logic [2:0] SH_SLL = 3'b000;
  localparam logic [2:0] SH_SRL = 3'b001;
  localparam logic [2:0] SH_SRA = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;
  localparam logic [2:0] SH_ROL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // 101-111 carry the operand through untouched.
  function automatic logic is_pass(input logic [2:0] op);
    return op > SH_ROL;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the datapath control and the shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (output start, op, shamt, din, input dout, busy, done);
  modport slave  (input start, op, shamt, din, output dout, busy, done);
endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate of a value; pass-through for unused op codes.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  always_comb begin
    val_o = val_i;
    case (op_i)
      SH_SLL:  val_o = {val_i[WIDTH-2:0], 1'b0};
      SH_SRL:  val_o = {1'b0, val_i[WIDTH-1:1]};
      SH_SRA:  val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
      SH_ROR:  val_o = {val_i[0], val_i[WIDTH-1:1]};
      SH_ROL:  val_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
      default: val_o = val_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle shift unit: captures a request, steps one bit per cycle, pulses done when dout is final.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] step_val;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .val_i (dout_q),
    .val_o (step_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      op_q    <= SH_SLL;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_SHIFT: begin
        dout_d = step_val;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) state_d = ST_DONE;
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        state_d = ST_IDLE;
        if (bus.start) begin
          dout_d  = bus.din;
          cnt_d   = bus.shamt;
          op_d    = bus.op;
          state_d = (bus.shamt == '0 || is_pass(bus.op)) ? ST_DONE : ST_SHIFT;
        end
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, busy length, result and reset behaviour.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  shift_sequencer_if #(.WIDTH(32), .SHW(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Issues one request, then samples 1 ns after each edge until done or budget expiry.
  task automatic run(input string tag, input logic [2:0] o, input logic [4:0] sa,
                     input logic [31:0] d, input logic [31:0] exp,
                     input int lat, input int nbusy, input int repulse);
    int cyc, busy_n;
    bit got;
    bus.start = 1'b1; bus.op = o; bus.shamt = sa; bus.din = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; busy_n = 0; got = 0;
    while (cyc <= 40 && !got) begin
      if (bus.done) got = 1;
      else begin
        if (bus.busy) busy_n++;
        if (repulse == cyc) begin
          bus.start = 1'b1; bus.din = '0; bus.op = SH_SLL; bus.shamt = '0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_lat"},  got ? cyc : 0, lat);
    chk({tag, "_busy"}, busy_n, nbusy);
    chk({tag, "_dout"}, bus.dout, exp);
  endtask

  initial begin
    int dn;
    n_chk = 0; n_pass = 0;
    bus.start = 1'b0; bus.op = '0; bus.shamt = '0; bus.din = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_busy", bus.busy, 32'h0);
    chk("rst_done", bus.done, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("sll16",  SH_SLL, 5'd16, 32'h0000ABCD, 32'hABCD0000, 17, 16, 0);
    @(posedge clk); #1;
    chk("done_1cyc", bus.done, 32'h0);
    chk("hold_idle", bus.dout, 32'hABCD0000);

    run("sra4",   SH_SRA, 5'd4,  32'h80000000, 32'hF8000000, 5, 4, 0);
    run("srl4",   SH_SRL, 5'd4,  32'h80000000, 32'h08000000, 5, 4, 0);
    run("sra2p",  SH_SRA, 5'd2,  32'h40000000, 32'h10000000, 3, 2, 0);
    run("ror1",   SH_ROR, 5'd1,  32'h00000001, 32'h80000000, 2, 1, 0);
    run("rol31",  SH_ROL, 5'd31, 32'h00000001, 32'h80000000, 32, 31, 0);
    run("rol1",   SH_ROL, 5'd1,  32'h80000001, 32'h00000003, 2, 1, 0);
    run("zero",   SH_SLL, 5'd0,  32'h12345678, 32'h12345678, 1, 0, 0);
    run("pass7",  3'b111, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 0);
    @(posedge clk); #1;

    // Re-pulse in cycle 3 must be ignored; the next run starts inside the DONE cycle.
    run("ign",    SH_SRL, 5'd8,  32'hFF000000, 32'h00FF0000, 9, 8, 3);
    run("b2b",    SH_SLL, 5'd4,  32'h0000000F, 32'h000000F0, 5, 4, 0);
    @(posedge clk); #1;
    chk("b2b_once", bus.done, 32'h0);
    chk("b2b_hold", bus.dout, 32'h000000F0);

    // Abort a 20-step shift with an asynchronous reset between edges.
    bus.start = 1'b1; bus.op = SH_SLL; bus.shamt = 5'd20; bus.din = 32'h00000001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_pre", bus.busy, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_dout", bus.dout, 32'h0);
    chk("mid_busy", bus.busy, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("mid_nodone", dn, 0);
    chk("mid_idle",   bus.busy, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle shift execution unit for the CPU datapath.
- Sits directly downstream of the shift-amount/operand select muxes:
  - consumes a 5-bit shift amount (rs-low bits, shamt field, or constant 16 for lui);
  - consumes a 32-bit operand (A, B, or zero-extended immediate).
- Performs SLL/SRL/SRA/ROR/ROL one bit per cycle under a start/busy/done handshake.
- The control FSM waits on done before writing dout to the register file.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when accepting.
- op  input  3  shift operation, captured on accepted start.
- shamt  input  SHW  shift amount, captured on accepted start.
- din  input  WIDTH  operand, captured on accepted start.
- dout  output  WIDTH  result register.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse: dout is final.

Behaviour:
- Interface: one clock, clk; reset is asynchronous, active-high, named reset.
- Reset values: state=IDLE, dout=0, cnt=0, op_q=SLL, busy=0, done=0. Reset asserted mid-operation aborts immediately; no done pulse follows.
- op encoding:
  - 000 SLL, zero fill.
  - 001 SRL, zero fill.
  - 010 SRA, msb fill.
  - 011 ROR.
  - 100 ROL.
  - 101-111: pass-through, treated as shamt=0.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Start acceptance: start is accepted when state is IDLE or DONE. On accept:
  - dout<=din, cnt<=shamt, op_q<=op;
  - if shamt==0 or op is pass-through, next state = DONE, else next state = SHIFT.
- start in SHIFT: ignored. Captured operands are unaffected; no queuing.
- SHIFT, each cycle:
  - dout <= one-bit step of op_q applied to dout; cnt <= cnt-1;
  - if cnt==1, next state = DONE.
- DONE:
  - lasts exactly one cycle; next state is IDLE unless a new start is accepted.
  - dout holds its value through DONE and IDLE until the next accepted start.
- Latency: done asserts N+1 cycles after the start edge, where N = effective shamt (0..31). Maximum is 32 cycles.
- shamt is mod 2^SHW by width. ROR/ROL by 31 is legal. A shift of 32 is not representable.
- SRA on a negative operand fills with 1s every step. SRL/SLL fill with 0.
- Back-to-back: start asserted in the DONE cycle is accepted. done pulses once per accepted start.

Decomposition:
- shift_pkg holds:
  - op localparams SH_SLL, SH_SRL, SH_SRA, SH_ROR, SH_ROL;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE;
  - WIDTH default.
- One combinational sub-module, shift_step:
  - inputs: op, 32-bit value;
  - output: value shifted/rotated by one bit.
  - The top holds the FSM, counter and result register, and instantiates shift_step once.

Test Plan:
- Reset then SLL:
  - Stimulus: reset pulse; start with op=000, shamt=16, din=0x0000ABCD.
  - Response: busy high cycles 1-16; done pulse at cycle 17; dout=0xABCD0000 (lui path).
- SRA sign fill:
  - Stimulus: op=010, shamt=4, din=0x80000000.
  - Response: done at cycle 5; dout=0xF8000000.
  - Repeat with op=001: dout=0x08000000.
- Rotates:
  - op=011, shamt=1, din=0x00000001 -> dout=0x80000000.
  - op=100, shamt=31, din=0x00000001 -> dout=0x80000000 after 32 cycles.
- Zero shift / pass-through:
  - op=000, shamt=0, din=0x12345678 -> done at cycle 1, busy never high, dout=0x12345678.
  - op=111, shamt=9 -> same timing, dout=din.
- Ignored and back-to-back starts:
  - Stimulus: start op=001, shamt=8, din=0xFF000000; re-pulse start at cycle 3 with din=0.
  - Response: ignored; done at cycle 9 with dout=0x00FF0000.
  - Then: start in the DONE cycle is accepted; a second done follows.
- Reset mid-operation:
  - Stimulus: assert reset at cycle 5 of a shamt=20 shift, asynchronously between edges.
  - Response: dout=0, busy=0 immediately; no done pulse afterwards.
